imem_loader: RTL and testbench
==============================

# imem_loader

Boot-time program loader that writes the instruction memory. Accepts a framed byte stream (16-bit word count, little-endian payload, XOR checksum) over a valid/ready interface. Assembles each 4 bytes into a little-endian 32-bit word and issues one word write per word into the instruction memory's write port. Holds the CPU core until a load completes successfully.

## Interface

Parameters:
- MEM_BYTES, 4096: instruction memory size in bytes; max load = MEM_BYTES/4 words.
- ADDR_W, 12: byte-address width, log2(MEM_BYTES).
- BASE_ADDR, 0: byte address of the first word written; must be a multiple of 4.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a load from IDLE, DONE or ERR.
- in_valid  in  1  byte-stream valid.
- in_data  in  8  byte-stream data.
- in_ready  out  1  byte-stream ready; a byte transfers when in_valid && in_ready.
- mem_we  out  1  one-cycle word-write strobe.
- mem_addr  out  ADDR_W  byte address of the word, always 4-aligned.
- mem_wdata  out  32  word, byte0 in [7:0] … byte3 in [31:24].
- cpu_hold  out  1  holds the core in reset while high.
- done  out  1  load finished with good checksum.
- error  out  1  load aborted (bad length or bad checksum).
- words_loaded  out  ADDR_W-1  count of words written in the current/last load.

## Operation

- States: IDLE, LEN_LO, LEN_HI, DATA, CSUM, DONE, ERR.
- IDLE: in_ready=0. start -> LEN_LO and clear words_loaded, byte index, checksum, done, error.
- LEN_LO: accept byte -> len[7:0], go LEN_HI.
- LEN_HI: accept byte -> len[15:8]. If len==0 or len>MEM_BYTES/4 -> ERR, no writes. Else -> DATA.
- DATA: each accepted byte XORs into the checksum register and fills lane byte_idx (0..3) of the assembly register. On lane 3: schedule a write, increment words_loaded. When words_loaded reaches len -> CSUM.
- CSUM: accept one byte. If it equals the checksum register -> DONE, else -> ERR.
- DONE: done=1. ERR: error=1. Both hold until start or reset.
- start is ignored in LEN_LO, LEN_HI, DATA and CSUM.
- Address: mem_addr = (BASE_ADDR + 4*word_index) truncated to ADDR_W bits, so it wraps modulo MEM_BYTES.
- Checksum covers payload bytes only. It excludes the length bytes and the checksum byte.
- Words already written before an ERR from a checksum failure stay in memory. No rollback.
- cpu_hold is decoded from state: 0 only in DONE, 1 in every other state.

## Timing

- Reset values: state IDLE, in_ready 0, mem_we 0, mem_addr 0, mem_wdata 0, cpu_hold 1, done 0, error 0, words_loaded 0.
- in_ready is 1 in LEN_LO, LEN_HI, DATA and CSUM, and 0 otherwise. There are no stall cycles and no dependence on in_valid.
- The first byte can be accepted in the cycle after start is sampled.
- mem_we is a registered one-cycle pulse, asserted in the cycle after the 4th byte of a word is accepted. mem_addr and mem_wdata are valid in that same cycle.
- Back-to-back words are allowed: a write pulse can coincide with acceptance of the next byte, including the checksum byte.
- done, error and the DONE/ERR state take effect in the cycle after the deciding byte is accepted. cpu_hold falls in that same cycle.
- Gaps in in_valid only stretch the load. Behaviour is otherwise identical.
- Reset in any state returns to IDLE on the next edge. A pending write pulse is cancelled, so mem_we=0 in the cycle after reset is sampled.

## Test plan

- Nominal load: start, then bytes 02 00 78 56 34 12 EF BE AD DE 2A -> writes 0x12345678 @0x000 and 0xDEADBEEF @0x004. Final state: done=1, error=0, cpu_hold=0, words_loaded=2.
- Bad checksum: same stream with last byte 2B -> the same two writes occur, then error=1, done=0, cpu_hold=1. A subsequent start with the good stream -> done=1.
- Bad length: header 00 00 -> ERR with no mem_we. Header 01 04 (1025) -> ERR with no mem_we. start is ignored while mid-load.
- Throttled source: the nominal stream with in_valid low on random cycles (≥50%) -> identical writes and result. mem_we pulses exactly twice.
- Reset mid-payload: reset after 5 payload bytes -> IDLE, in_ready=0, mem_we=0, cpu_hold=1, words_loaded=0. A following full nominal load succeeds.
- Max load with BASE_ADDR=0x800, len=1024 (00 04): addresses run 0x800…0xFFC then wrap to 0x000…0x7FC. words_loaded=1024, done=1.

Source files
------------

// File: rtl/imem_loader.sv
// Boot-time instruction memory loader: framed byte stream (length, LE payload,
// XOR checksum) assembled into 32-bit word writes; holds the CPU until done.
module imem_loader #(
  parameter int MEM_BYTES = 4096,
  parameter int ADDR_W    = 12,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              error,
  output logic [ADDR_W-2:0] words_loaded
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LEN_LO = 3'd1;
  localparam logic [2:0] S_LEN_HI = 3'd2;
  localparam logic [2:0] S_DATA   = 3'd3;
  localparam logic [2:0] S_CSUM   = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;
  localparam logic [2:0] S_ERR    = 3'd6;

  localparam logic [31:0]       MAX_WORDS = 32'(MEM_BYTES / 4);
  localparam logic [ADDR_W-1:0] BASE      = ADDR_W'(BASE_ADDR);

  logic [2:0]        state_q, state_d;
  logic [15:0]       len_q, len_d;
  logic [1:0]        byte_idx_q, byte_idx_d;
  logic [7:0]        csum_q, csum_d;
  logic [23:0]       asm_q, asm_d;
  logic [ADDR_W-2:0] wl_q, wl_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic [15:0]       len_full;

  assign len_full = {in_data, len_q[7:0]};

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    byte_idx_d  = byte_idx_q;
    csum_d      = csum_q;
    asm_d       = asm_q;
    wl_d        = wl_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          state_d    = S_LEN_LO;
          wl_d       = '0;
          byte_idx_d = '0;
          csum_d     = '0;
        end
      end
      S_LEN_LO: begin
        if (in_valid) begin
          len_d   = {len_q[15:8], in_data};
          state_d = S_LEN_HI;
        end
      end
      S_LEN_HI: begin
        if (in_valid) begin
          len_d = len_full;
          if (len_full == 16'd0 || 32'(len_full) > MAX_WORDS) state_d = S_ERR;
          else                                                  state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (in_valid) begin
          csum_d     = csum_q ^ in_data;
          byte_idx_d = byte_idx_q + 2'd1;
          case (byte_idx_q)
            2'd0: asm_d[7:0]   = in_data;
            2'd1: asm_d[15:8]  = in_data;
            2'd2: asm_d[23:16] = in_data;
            default: begin
              // Address uses the pre-increment count: it is this word's index.
              mem_we_d    = 1'b1;
              mem_wdata_d = {in_data, asm_q};
              mem_addr_d  = BASE + ADDR_W'({wl_q, 2'b00});
              wl_d        = wl_q + 1'b1;
              if (32'(wl_q) + 32'd1 == 32'(len_q)) state_d = S_CSUM;
            end
          endcase
        end
      end
      S_CSUM: begin
        if (in_valid) state_d = (in_data == csum_q) ? S_DONE : S_ERR;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      len_q       <= '0;
      byte_idx_q  <= '0;
      csum_q      <= '0;
      asm_q       <= '0;
      wl_q        <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      byte_idx_q  <= byte_idx_d;
      csum_q      <= csum_d;
      asm_q       <= asm_d;
      wl_q        <= wl_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign in_ready     = (state_q == S_LEN_LO) || (state_q == S_LEN_HI) ||
                        (state_q == S_DATA)   || (state_q == S_CSUM);
  assign mem_we       = mem_we_q;
  assign mem_addr     = mem_addr_q;
  assign mem_wdata    = mem_wdata_q;
  assign cpu_hold     = (state_q != S_DONE);
  assign done         = (state_q == S_DONE);
  assign error        = (state_q == S_ERR);
  assign words_loaded = wl_q;

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: two instances (base 0x000 and 0x800) share
// one byte stream; per-instance monitors pop expected writes on each mem_we.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        reset, start, in_valid;
  logic [7:0]  in_data;
  logic        rdy0, we0, hold0, done0, err0;
  logic        rdy1, we1, hold1, done1, err1;
  logic [11:0] addr0, addr1;
  logic [31:0] wdata0, wdata1;
  logic [10:0] wl0, wl1;

  int tests = 0;
  int fails = 0;
  int we_cnt0 = 0;
  int we_cnt1 = 0;
  logic [43:0] q0[$];
  logic [43:0] q1[$];

  always #5 clk = ~clk;

  imem_loader #(.MEM_BYTES(4096), .ADDR_W(12), .BASE_ADDR(0)) u0 (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(rdy0), .mem_we(we0), .mem_addr(addr0), .mem_wdata(wdata0),
    .cpu_hold(hold0), .done(done0), .error(err0), .words_loaded(wl0));

  imem_loader #(.MEM_BYTES(4096), .ADDR_W(12), .BASE_ADDR(32'h800)) u1 (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(rdy1), .mem_we(we1), .mem_addr(addr1), .mem_wdata(wdata1),
    .cpu_hold(hold1), .done(done1), .error(err1), .words_loaded(wl1));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    logic [43:0] e;
    if (we0) begin
      we_cnt0++;
      tests++;
      if (q0.size() == 0) begin
        fails++;
        $display("FAIL write0: got addr %h data %h expected no write", addr0, wdata0);
      end else begin
        e = q0.pop_front();
        if ({addr0, wdata0} !== e) begin
          fails++;
          $display("FAIL write0: got addr %h data %h expected addr %h data %h",
                   addr0, wdata0, e[43:32], e[31:0]);
        end
      end
    end
  end

  always @(negedge clk) begin
    logic [43:0] e;
    if (we1) begin
      we_cnt1++;
      tests++;
      if (q1.size() == 0) begin
        fails++;
        $display("FAIL write1: got addr %h data %h expected no write", addr1, wdata1);
      end else begin
        e = q1.pop_front();
        if ({addr1, wdata1} !== e) begin
          fails++;
          $display("FAIL write1: got addr %h data %h expected addr %h data %h",
                   addr1, wdata1, e[43:32], e[31:0]);
        end
      end
    end
  end

  function automatic logic [31:0] gen_word(input int i);
    logic [15:0] v;
    v = 16'(i);
    if (i == 0) return 32'h12345678;
    if (i == 1) return 32'hDEADBEEF;
    return {v[7:0] ^ 8'h5A, v[15:8], ~v[7:0], v[7:0] + 8'h11};
  endfunction

  task automatic send(input logic [7:0] b, input bit thr);
    int cnt;
    if (thr) begin
      in_valid = 1'b0;
      repeat ($urandom_range(1, 3)) @(negedge clk);
    end
    in_valid = 1'b1;
    in_data  = b;
    cnt = 0;
    while (!rdy0 && cnt < 50) begin
      @(negedge clk);
      cnt++;
    end
    if (cnt >= 50) begin
      fails++;
      tests++;
      $display("FAIL send_timeout: got in_ready %b expected 1", rdy0);
    end else begin
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_load(input int n, input logic [15:0] len, input bit bad,
                          input bit thr, input bit mid_start);
    logic [7:0]  cs;
    logic [31:0] w;
    do_start();
    send(len[7:0], thr);
    send(len[15:8], thr);
    cs = 8'h00;
    for (int i = 0; i < n; i++) begin
      w = gen_word(i);
      for (int b = 0; b < 4; b++) begin
        cs = cs ^ w[8*b +: 8];
        if (b == 3) begin
          q0.push_back({12'(4 * i), w});
          q1.push_back({12'(32'h800 + 4 * i), w});
        end
        start = (mid_start && i == 0 && b == 1);
        send(w[8*b +: 8], thr);
        start = 1'b0;
      end
    end
    send(bad ? (cs ^ 8'h01) : cs, thr);
  endtask

  task automatic status(input string tag, input logic d, input logic e,
                        input logic h, input logic [10:0] wl);
    check({tag, "_done0"}, 32'(done0), 32'(d));
    check({tag, "_err0"},  32'(err0),  32'(e));
    check({tag, "_hold0"}, 32'(hold0), 32'(h));
    check({tag, "_wl0"},   32'(wl0),   32'(wl));
    check({tag, "_done1"}, 32'(done1), 32'(d));
    check({tag, "_wl1"},   32'(wl1),   32'(wl));
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("rst_ready", 32'(rdy0), 32'd0);
    check("rst_we",    32'(we0),  32'd0);
    check("rst_addr",  32'(addr0), 32'd0);
    check("rst_wdata", wdata0, 32'd0);
    status("rst", 1'b0, 1'b0, 1'b1, 11'd0);

    run_load(2, 16'd2, 1'b0, 1'b0, 1'b0);
    status("nominal", 1'b1, 1'b0, 1'b0, 11'd2);
    check("nominal_ready", 32'(rdy0), 32'd0);

    run_load(2, 16'd2, 1'b1, 1'b0, 1'b0);
    status("badcsum", 1'b0, 1'b1, 1'b1, 11'd2);
    run_load(2, 16'd2, 1'b0, 1'b0, 1'b0);
    status("recover", 1'b1, 1'b0, 1'b0, 11'd2);

    do_start();
    send(8'h00, 1'b0);
    send(8'h00, 1'b0);
    status("len0", 1'b0, 1'b1, 1'b1, 11'd0);
    do_start();
    send(8'h01, 1'b0);
    send(8'h04, 1'b0);
    status("len1025", 1'b0, 1'b1, 1'b1, 11'd0);

    run_load(2, 16'd2, 1'b0, 1'b0, 1'b1);
    status("midstart", 1'b1, 1'b0, 1'b0, 11'd2);

    @(negedge clk);
    we_cnt0 = 0;
    run_load(2, 16'd2, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    status("throttle", 1'b1, 1'b0, 1'b0, 11'd2);
    check("throttle_we_count", 32'(we_cnt0), 32'd2);

    do_start();
    send(8'h02, 1'b0);
    send(8'h00, 1'b0);
    q0.push_back({12'h000, 32'h12345678});
    q1.push_back({12'h800, 32'h12345678});
    send(8'h78, 1'b0); send(8'h56, 1'b0); send(8'h34, 1'b0); send(8'h12, 1'b0);
    send(8'hEF, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("rstmid_ready", 32'(rdy0), 32'd0);
    check("rstmid_we",    32'(we0),  32'd0);
    status("rstmid", 1'b0, 1'b0, 1'b1, 11'd0);
    run_load(2, 16'd2, 1'b0, 1'b0, 1'b0);
    status("afterrst", 1'b1, 1'b0, 1'b0, 11'd2);

    run_load(1024, 16'h0400, 1'b0, 1'b0, 1'b0);
    status("maxload", 1'b1, 1'b0, 1'b0, 11'd1024);

    repeat (2) @(negedge clk);
    check("q0_empty", 32'(q0.size()), 32'd0);
    check("q1_empty", 32'(q1.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
